// File: rtl/ramwb_delay_arbiter_pkg.sv
// Shared encodings for the delayed SDRAM Wishbone arbiter.
package ramwb_delay_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int BEAT_W = 4;

    // Cache-inhibited accesses are single beats; cacheable ones fill a line.
    function automatic logic [BEAT_W-1:0] burst_len(input logic ci, input int unsigned line_beats);
        return ci ? BEAT_W'(1) : BEAT_W'(line_beats);
    endfunction

endpackage

// File: rtl/ramwb_delay_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; last_gnt=1 means m1 was served last.
module rr_arb2
    import ramwb_delay_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (req == 2'b11) begin
            gnt = last_gnt ? GNT_M0 : GNT_M1;
        end else if (req[0]) begin
            gnt = GNT_M0;
        end else if (req[1]) begin
            gnt = GNT_M1;
        end
    end

endmodule

// File: rtl/ramwb_delay_arbiter.sv
// Shares one SDRAM Wishbone slave between the or1200 data (m0) and instruction
// (m1) BIUs, inserting a programmable wait before every granted transaction.
module ramwb_delay_arbiter
    import ramwb_delay_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LINE_BEATS = 8,
    parameter int DLY_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DLY_W-1:0] cfg_delay,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic             m0_ci_i,
    input  logic [AW-1:0]    m0_adr_i,
    input  logic [DW-1:0]    m0_dat_i,
    output logic [DW-1:0]    m0_dat_o,
    output logic             m0_ack_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic             m1_ci_i,
    input  logic [AW-1:0]    m1_adr_i,
    input  logic [DW-1:0]    m1_dat_i,
    output logic [DW-1:0]    m1_dat_o,
    output logic             m1_ack_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [DW-1:0]    s_dat_o,
    input  logic [DW-1:0]    s_dat_i,
    input  logic             s_ack_i,

    output logic [1:0]       gnt_o,
    output logic             busy_o
);

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;
    logic              s_cyc_q, s_cyc_d;
    logic              s_we_q, s_we_d;

    logic [1:0]        req;
    logic [1:0]        arb_gnt;
    logic              gnt_cyc;
    logic              xfer_ack;
    logic              sel_we;
    logic              sel_ci;

    assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    rr_arb2 u_arb (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt)
    );

    // Granted master still holding cyc; losing it aborts DELAY or XFER.
    assign gnt_cyc  = (gnt_q[0] & m0_cyc_i) | (gnt_q[1] & m1_cyc_i);
    assign xfer_ack = s_ack_i & gnt_cyc & (state_q == XFER);
    assign sel_we   = arb_gnt[1] ? m1_we_i : m0_we_i;
    assign sel_ci   = arb_gnt[1] ? m1_ci_i : m0_ci_i;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        beats_d    = beats_q;
        cnt_d      = cnt_q;
        s_cyc_d    = s_cyc_q;
        s_we_d     = s_we_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = arb_gnt;
                    we_d    = sel_we;
                    beats_d = burst_len(sel_ci, LINE_BEATS);
                    cnt_d   = en ? cfg_delay : '0;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (!gnt_cyc) begin
                    state_d = RELEASE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DLY_W'(1);
                end else begin
                    state_d = XFER;
                    s_cyc_d = 1'b1;
                    s_we_d  = we_q;
                end
            end
            XFER: begin
                if (!gnt_cyc) begin
                    state_d = RELEASE;
                    s_cyc_d = 1'b0;
                    s_we_d  = 1'b0;
                end else if (s_ack_i) begin
                    beats_d = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) begin
                        state_d = RELEASE;
                        s_cyc_d = 1'b0;
                        s_we_d  = 1'b0;
                    end
                end
            end
            RELEASE: begin
                s_cyc_d    = 1'b0;
                s_we_d     = 1'b0;
                last_gnt_d = gnt_q[1];
                gnt_d      = GNT_NONE;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                s_cyc_d = 1'b0;
                s_we_d  = 1'b0;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_NONE;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            beats_q    <= '0;
            cnt_q      <= '0;
            s_cyc_q    <= 1'b0;
            s_we_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            beats_q    <= beats_d;
            cnt_q      <= cnt_d;
            s_cyc_q    <= s_cyc_d;
            s_we_q     <= s_we_d;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        if (gnt_q[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end else if (gnt_q[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end
    end

    assign s_cyc_o  = s_cyc_q;
    assign s_stb_o  = s_cyc_q;
    assign s_we_o   = s_we_q;
    assign gnt_o    = gnt_q;
    assign busy_o   = (state_q != IDLE);
    assign m0_ack_o = xfer_ack & gnt_q[0];
    assign m1_ack_o = xfer_ack & gnt_q[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
